// File: rtl/automata_stage_pkg.sv
// rtl/automata_stage_pkg.sv - shared constants and helpers for the automata report stage
package automata_stage_pkg;

    localparam int SYMBOL_W_DEF   = 8;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int OFFSET_W_DEF   = 32;
    localparam int DROP_COUNT_W   = 16;
    localparam int REPORT_COUNT_W = 32;

    // Pointer width for a power-of-two depth; never below one bit.
    function automatic int ptr_width(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/automata_report_fifo.sv
// rtl/automata_report_fifo.sv - first-word-fall-through FIFO with occupancy count
module automata_report_fifo
    import automata_stage_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero while empty so the outputs never expose stale entries.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/automata_stage_report_buffer.sv
// rtl/automata_stage_report_buffer.sv - symbol pipeline stage with tagged report FIFO; AUTOMATA_STAGE_REPORT_COUNT_EN enables report_count
module automata_stage_report_buffer
    import automata_stage_pkg::*;
#(
    parameter int SYMBOL_W             = SYMBOL_W_DEF,
    parameter int NUM_AUTOMATA         = 7,
    parameter int REPORTS_PER_AUTOMATA = 4,
    parameter int FIFO_DEPTH           = FIFO_DEPTH_DEF,
    parameter int OFFSET_W             = OFFSET_W_DEF
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         run,
    input  logic [SYMBOL_W-1:0]                          top_symbols,
    input  logic [NUM_AUTOMATA*REPORTS_PER_AUTOMATA-1:0] report_in,
    output logic [SYMBOL_W-1:0]                          out_symbols,
    output logic                                         out_run,
    output logic                                         out_reset,
    output logic                                         report_valid,
    input  logic                                         report_ready,
    output logic [NUM_AUTOMATA*REPORTS_PER_AUTOMATA-1:0] report_vector,
    output logic [OFFSET_W-1:0]                          report_offset,
    output logic                                         overflow,
    output logic [DROP_COUNT_W-1:0]                      drop_count,
    output logic [REPORT_COUNT_W-1:0]                    report_count
);

    localparam int REPORT_W = NUM_AUTOMATA * REPORTS_PER_AUTOMATA;
    localparam int ENTRY_W  = REPORT_W + OFFSET_W;

    logic [OFFSET_W-1:0] offset;
    logic [ENTRY_W-1:0]  head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push_req;
    logic                pop;
    logic                push_ok;
    logic                drop;

    always_ff @(posedge clk) begin
        out_reset <= reset;
        if (reset) begin
            out_symbols <= '0;
            out_run     <= 1'b0;
        end else begin
            out_run <= run;
            if (run) begin
                out_symbols <= top_symbols;
            end
        end
    end

    // The tag is the offset before this cycle's increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            offset <= '0;
        end else if (run) begin
            offset <= offset + 1'b1;
        end
    end

    assign push_req = run && (report_in != '0) && !reset;
    assign pop      = report_valid && report_ready;
    assign push_ok  = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    automata_report_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .push_data ({report_in, offset}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign report_valid  = !fifo_empty;
    assign report_vector = head[ENTRY_W-1:OFFSET_W];
    assign report_offset = head[OFFSET_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

`ifdef AUTOMATA_STAGE_REPORT_COUNT_EN
    logic [REPORT_COUNT_W-1:0] report_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            report_count_q <= '0;
        end else if (push_ok && report_count_q != '1) begin
            report_count_q <= report_count_q + 1'b1;
        end
    end

    assign report_count = report_count_q;
`else
    assign report_count = '0;
`endif

endmodule

// File: tb/tb_automata_stage_report_buffer.sv
// tb/tb_automata_stage_report_buffer.sv - directed vector bench for automata_stage_report_buffer
module tb_automata_stage_report_buffer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [7:0]  top_symbols;
    logic [27:0] report_in;
    logic [7:0]  out_symbols;
    logic        out_run;
    logic        out_reset;
    logic        report_valid;
    logic        report_ready;
    logic [27:0] report_vector;
    logic [31:0] report_offset;
    logic        overflow;
    logic [15:0] drop_count;
    logic [31:0] report_count;

    int total;
    int bad;

    automata_stage_report_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .top_symbols   (top_symbols),
        .report_in     (report_in),
        .out_symbols   (out_symbols),
        .out_run       (out_run),
        .out_reset     (out_reset),
        .report_valid  (report_valid),
        .report_ready  (report_ready),
        .report_vector (report_vector),
        .report_offset (report_offset),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .report_count  (report_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        run;
        logic [7:0]  sym;
        logic [27:0] rep;
        logic        rdy;
        logic [7:0]  e_sym;
        logic        e_run;
        logic        e_rst;
        logic        e_val;
        logic [27:0] e_vec;
        logic [31:0] e_off;
        logic        e_ovf;
        logic [15:0] e_dc;
    } vec_t;

    vec_t tv [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic ru, input logic [7:0] s,
                         input logic [27:0] rp, input logic rd);
        reset        = r;
        run          = ru;
        top_symbols  = s;
        report_in    = rp;
        report_ready = rd;
    endtask

    logic [31:0] exp_count;

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b1, 1'b0, 8'h00, 28'h0, 1'b0);

        //        rst   run   sym    rep          rdy   e_sym  e_run e_rst e_val e_vec        e_off  e_ovf e_dc
        tv[0]  = '{1'b1, 1'b0, 8'h00, 28'h0000000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 28'h0000000, 32'd0, 1'b0, 16'd0};
        tv[1]  = '{1'b0, 1'b1, 8'h41, 28'h0000000, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0, 28'h0000000, 32'd0, 1'b0, 16'd0};
        tv[2]  = '{1'b0, 1'b1, 8'h42, 28'h0000000, 1'b0, 8'h42, 1'b1, 1'b0, 1'b0, 28'h0000000, 32'd0, 1'b0, 16'd0};
        tv[3]  = '{1'b0, 1'b1, 8'h43, 28'h0000000, 1'b0, 8'h43, 1'b1, 1'b0, 1'b0, 28'h0000000, 32'd0, 1'b0, 16'd0};
        tv[4]  = '{1'b0, 1'b1, 8'h44, 28'h0000000, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0, 28'h0000000, 32'd0, 1'b0, 16'd0};
        tv[5]  = '{1'b1, 1'b0, 8'h00, 28'h0000000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 28'h0000000, 32'd0, 1'b0, 16'd0};
        tv[6]  = '{1'b0, 1'b1, 8'h50, 28'h0000000, 1'b0, 8'h50, 1'b1, 1'b0, 1'b0, 28'h0000000, 32'd0, 1'b0, 16'd0};
        tv[7]  = '{1'b0, 1'b1, 8'h51, 28'h0000000, 1'b0, 8'h51, 1'b1, 1'b0, 1'b0, 28'h0000000, 32'd0, 1'b0, 16'd0};
        tv[8]  = '{1'b0, 1'b1, 8'h52, 28'h0000010, 1'b1, 8'h52, 1'b1, 1'b0, 1'b1, 28'h0000010, 32'd2, 1'b0, 16'd0};
        tv[9]  = '{1'b0, 1'b0, 8'h53, 28'h0000000, 1'b1, 8'h52, 1'b0, 1'b0, 1'b0, 28'h0000000, 32'd0, 1'b0, 16'd0};
        tv[10] = '{1'b0, 1'b1, 8'h60, 28'h0000001, 1'b0, 8'h60, 1'b1, 1'b0, 1'b1, 28'h0000001, 32'd3, 1'b0, 16'd0};
        tv[11] = '{1'b0, 1'b0, 8'h61, 28'h0000002, 1'b0, 8'h60, 1'b0, 1'b0, 1'b1, 28'h0000001, 32'd3, 1'b0, 16'd0};
        tv[12] = '{1'b0, 1'b1, 8'h62, 28'h0000004, 1'b1, 8'h62, 1'b1, 1'b0, 1'b1, 28'h0000004, 32'd4, 1'b0, 16'd0};
        tv[13] = '{1'b0, 1'b0, 8'h63, 28'h0000000, 1'b1, 8'h62, 1'b0, 1'b0, 1'b0, 28'h0000000, 32'd0, 1'b0, 16'd0};

        for (int i = 0; i < 14; i++) begin
            drive(tv[i].rst, tv[i].run, tv[i].sym, tv[i].rep, tv[i].rdy);
            tick();
            check($sformatf("v%0d out_symbols", i), 64'(out_symbols), 64'(tv[i].e_sym));
            check($sformatf("v%0d out_run", i), 64'(out_run), 64'(tv[i].e_run));
            check($sformatf("v%0d out_reset", i), 64'(out_reset), 64'(tv[i].e_rst));
            check($sformatf("v%0d report_valid", i), 64'(report_valid), 64'(tv[i].e_val));
            check($sformatf("v%0d report_vector", i), 64'(report_vector), 64'(tv[i].e_vec));
            check($sformatf("v%0d report_offset", i), 64'(report_offset), 64'(tv[i].e_off));
            check($sformatf("v%0d overflow", i), 64'(overflow), 64'(tv[i].e_ovf));
            check($sformatf("v%0d drop_count", i), 64'(drop_count), 64'(tv[i].e_dc));
        end

        // Overflow: ten reporting symbols with the consumer stalled.
        drive(1'b1, 1'b0, 8'h00, 28'h0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'(i), 28'(i + 1), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 8'h00, 28'h0, 1'b0);
        check("ovf report_valid", 64'(report_valid), 64'd1);
        check("ovf overflow", 64'(overflow), 64'd1);
        check("ovf drop_count", 64'(drop_count), 64'd2);
        tick();
        check("ovf head stable offset", 64'(report_offset), 64'd0);
        check("ovf head stable vector", 64'(report_vector), 64'd1);
        report_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d valid", i), 64'(report_valid), 64'd1);
            check($sformatf("drain%0d offset", i), 64'(report_offset), 64'(i));
            check($sformatf("drain%0d vector", i), 64'(report_vector), 64'(i + 1));
            tick();
        end
        check("drain empty", 64'(report_valid), 64'd0);
        check("drain overflow sticky", 64'(overflow), 64'd1);
        check("drain drop_count held", 64'(drop_count), 64'd2);

        // Reset with five entries queued; offset counter is at 10.
        report_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 8'h00, 28'(32'h100 + i), 1'b0);
            tick();
        end
        `ifdef AUTOMATA_STAGE_REPORT_COUNT_EN
        exp_count = 32'd13;
        `else
        exp_count = 32'd0;
        `endif
        check("q5 report_count", 64'(report_count), 64'(exp_count));
        check("q5 head offset", 64'(report_offset), 64'd10);
        drive(1'b1, 1'b1, 8'h77, 28'hFFF, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 28'h0, 1'b0);
        check("rst report_valid", 64'(report_valid), 64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        check("rst drop_count", 64'(drop_count), 64'd0);
        check("rst report_count", 64'(report_count), 64'd0);
        check("rst out_reset", 64'(out_reset), 64'd1);
        check("rst out_symbols", 64'(out_symbols), 64'd0);
        drive(1'b0, 1'b1, 8'h12, 28'h55, 1'b0);
        tick();
        check("post rst valid", 64'(report_valid), 64'd1);
        check("post rst offset", 64'(report_offset), 64'd0);
        check("post rst vector", 64'(report_vector), 64'h55);
        check("post rst out_reset", 64'(out_reset), 64'd0);

        // Full FIFO with simultaneous push and pop.
        drive(1'b1, 1'b0, 8'h00, 28'h0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h00, 28'(i + 1), 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 8'h00, 28'd9, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 28'h0, 1'b1);
        check("fullpp drop_count", 64'(drop_count), 64'd0);
        check("fullpp overflow", 64'(overflow), 64'd0);
        `ifdef AUTOMATA_STAGE_REPORT_COUNT_EN
        exp_count = 32'd9;
        `else
        exp_count = 32'd0;
        `endif
        check("fullpp report_count", 64'(report_count), 64'(exp_count));
        for (int i = 1; i < 9; i++) begin
            check($sformatf("fullpp%0d valid", i), 64'(report_valid), 64'd1);
            check($sformatf("fullpp%0d offset", i), 64'(report_offset), 64'(i));
            check($sformatf("fullpp%0d vector", i), 64'(report_vector), 64'(i + 1));
            tick();
        end
        check("fullpp empty", 64'(report_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
